gp_register_file: RTL and testbench
===================================

// Module: gp_register_file
// PURPOSE
// - Parametrised general-purpose register file for the CPU datapath: one bus write port,
//   one tri-state bus read port, two independent ALU read ports (A/B operands).
// - Adds a per-register busy scoreboard (reserve on issue, clear on writeback) with a hazard
//   flag for stall logic, plus bus-conflict detection. Sits between the control unit and ALU.
// PARAMETERS
// - DATA_W    16  width of each register and of data_bus / ALU outputs
// - ADDR_W     3  select width; register count NUM_REGS = 2**ADDR_W (derived localparam)
// - ZERO_REG   0  1: register 0 reads as 0, writes/reserves to it are ignored
// PORTS
// - clock           in     1        rising-edge clock
// - reset           in     1        reset, synchronous, active-high
// - reg_write       in     1        load data_bus into reg[input_select] this edge
// - input_select    in     ADDR_W   write destination index
// - reg_read        in     1        drive reg[output_select] onto data_bus
// - output_select   in     ADDR_W   bus read index
// - data_bus        inout  DATA_W   shared data bus; Z when reg_read=0
// - alu_a_select    in     ADDR_W   ALU operand A index
// - alu_b_select    in     ADDR_W   ALU operand B index
// - alu_a_value     out    DATA_W   reg[alu_a_select], combinational
// - alu_b_value     out    DATA_W   reg[alu_b_select], combinational
// - reserve         in     1        mark reg[reserve_select] busy (pending result)
// - reserve_select  in     ADDR_W   index to reserve
// - busy_mask       out    2**ADDR_W  registered busy bit per register
// - hazard          out    1        busy[alu_a_select] | busy[alu_b_select], combinational
// - bus_conflict    out    1        registered one-cycle pulse: write+read requested together
// BEHAVIOUR
// - Reset (has priority over all same-cycle requests): all registers 0, busy_mask 0,
//   bus_conflict 0; data_bus Z unless reg_read (reads return 0 after reset).
// - Write: at posedge with reg_write=1, reg_read=0: reg[input_select] <= data_bus and
//   busy[input_select] <= 0. New value visible on read ports the cycle after the edge.
// - reg_write=1 and reg_read=1 in the same cycle: write suppressed (block is driving the bus);
//   bus_conflict=1 for exactly the following cycle; busy unchanged; read proceeds normally.
// - Reserve: at posedge with reserve=1, busy[reserve_select] <= 1. Reserve and write-clear to
//   the same index on the same edge: set wins (new pending owner). Different indices: both apply.
// - Reads: data_bus = reg_read ? reg[output_select] : Z; ALU ports always driven; zero latency.
// - ZERO_REG=1: index 0 reads 0 on all ports, write ignored, reserve ignored, busy[0] stays 0.
// - hazard uses current busy_mask; a reservation made this edge raises hazard next cycle.
// - No out-of-range indices exist (NUM_REGS is a power of two).
// CONFIGURATION
// - GPR_BYPASS_EN defined: when reg_write=1, reg_read=0 and input_select matches an ALU select
//   (and is not index 0 with ZERO_REG=1), that ALU port returns data_bus in the same cycle and
//   the matching busy bit is masked out of hazard. data_bus read port is never bypassed.
// - GPR_BYPASS_EN undefined: ALU ports show the stored (old) value during the write cycle;
//   hazard reflects busy_mask only. Write-to-read latency 1 cycle.
// TESTING
// - Reset then read all 8 indices on ALU A/B and bus -> all 16'h0000, busy_mask 8'h00, bus Z.
// - Write 16'hBEEF to r3 (bus driven by bench), next cycle alu_a_select=3 -> 16'hBEEF;
//   reg_read=1 output_select=3 -> data_bus 16'hBEEF.
// - reserve r5 -> busy_mask 8'h20, alu_b_select=5 -> hazard=1; write 16'h1234 to r5 ->
//   busy_mask 8'h00, hazard=0, alu_b_value=16'h1234.
// - Same edge: reserve r2 + write r2=16'h00AA -> r2=16'h00AA, busy[2]=1;
//   reg_write+reg_read together -> no write, bus_conflict high exactly 1 cycle.
// - ZERO_REG=1: write 16'hFFFF to r0 and reserve r0 -> r0 reads 0, busy[0]=0; reset asserted
//   mid-sequence with writes pending -> all regs 0, busy_mask 0 next cycle.
// - GPR_BYPASS_EN: write 16'hCAFE to r4 with alu_a_select=4 -> alu_a_value 16'hCAFE same cycle,
//   hazard 0 even if r4 busy; without macro -> old value that cycle, 16'hCAFE next.

Source files
------------

// File: rtl/gp_register_file_if.sv
// gp_register_file_if
//   Control/ALU-side signal bundle of the general-purpose register file.
//   master: control unit / ALU side (drives selects and requests, observes values and status)
//   slave : register file side
// Signals:
//   reg_write, input_select        bus write request and destination index
//   reg_read, output_select        bus read request and source index
//   alu_a_select, alu_b_select     ALU operand indices
//   alu_a_value, alu_b_value       ALU operand values (combinational)
//   reserve, reserve_select        scoreboard reservation request and index
//   busy_mask                      registered busy bit per register
//   hazard                         operand busy flag for stall logic
//   bus_conflict                   one-cycle pulse after a simultaneous write+read request
interface gp_register_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic                reg_write;
  logic [ADDR_W-1:0]   input_select;
  logic                reg_read;
  logic [ADDR_W-1:0]   output_select;
  logic [ADDR_W-1:0]   alu_a_select;
  logic [ADDR_W-1:0]   alu_b_select;
  logic [DATA_W-1:0]   alu_a_value;
  logic [DATA_W-1:0]   alu_b_value;
  logic                reserve;
  logic [ADDR_W-1:0]   reserve_select;
  logic [NUM_REGS-1:0] busy_mask;
  logic                hazard;
  logic                bus_conflict;

  modport master (
    output reg_write, input_select, reg_read, output_select,
    output alu_a_select, alu_b_select, reserve, reserve_select,
    input  alu_a_value, alu_b_value, busy_mask, hazard, bus_conflict
  );

  modport slave (
    input  reg_write, input_select, reg_read, output_select,
    input  alu_a_select, alu_b_select, reserve, reserve_select,
    output alu_a_value, alu_b_value, busy_mask, hazard, bus_conflict
  );
endinterface

// File: rtl/gp_register_file.sv
// gp_register_file
//   General-purpose register file: one bus write port, one tri-state bus read port,
//   two combinational ALU read ports, per-register busy scoreboard with hazard flag,
//   and write/read bus-conflict detection.
// Ports:
//   clock     rising-edge clock
//   reset     synchronous, active-high; clears registers, busy mask and conflict flag
//   data_bus  shared tri-state data bus (written from, read onto when reg_read=1)
//   gpr       gp_register_file_if.slave (selects, requests, ALU values, status)
// Parameters:
//   DATA_W register width, ADDR_W select width (2**ADDR_W registers),
//   ZERO_REG=1 makes register 0 a hard-wired zero.
// Configuration macro:
//   GPR_BYPASS_EN  forward the in-flight bus write to matching ALU ports in the same
//                  cycle and mask the matching busy bit out of hazard.
module gp_register_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              reset,
  inout  wire  [DATA_W-1:0] data_bus,
  gp_register_file_if.slave gpr
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam bit ZR       = (ZERO_REG != 0);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_bus_conflict;

  logic                w_write_ok;
  logic                w_reserve_ok;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [DATA_W-1:0]   w_bus_rd_data;
  logic [DATA_W-1:0]   w_a_stored;
  logic [DATA_W-1:0]   w_b_stored;
  logic                w_byp_a;
  logic                w_byp_b;

  // A write is suppressed while this block drives the bus; register 0 is immutable with ZR.
  assign w_write_ok   = gpr.reg_write && !gpr.reg_read && !(ZR && gpr.input_select == '0);
  assign w_reserve_ok = gpr.reserve && !(ZR && gpr.reserve_select == '0);

  // Clear on writeback first, then set on reserve: a same-index reserve wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_write_ok)   w_busy_next[gpr.input_select]   = 1'b0;
    if (w_reserve_ok) w_busy_next[gpr.reserve_select] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_busy         <= '0;
      r_bus_conflict <= 1'b0;
    end else begin
      if (w_write_ok) r_regs[gpr.input_select] <= data_bus;
      r_busy         <= w_busy_next;
      r_bus_conflict <= gpr.reg_write && gpr.reg_read;
    end
  end

  assign w_bus_rd_data = (ZR && gpr.output_select == '0) ? '0 : r_regs[gpr.output_select];
  assign w_a_stored    = (ZR && gpr.alu_a_select  == '0) ? '0 : r_regs[gpr.alu_a_select];
  assign w_b_stored    = (ZR && gpr.alu_b_select  == '0) ? '0 : r_regs[gpr.alu_b_select];

  assign data_bus = gpr.reg_read ? w_bus_rd_data : 'z;

`ifdef GPR_BYPASS_EN
  assign w_byp_a = w_write_ok && (gpr.input_select == gpr.alu_a_select);
  assign w_byp_b = w_write_ok && (gpr.input_select == gpr.alu_b_select);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  assign gpr.alu_a_value  = w_byp_a ? data_bus : w_a_stored;
  assign gpr.alu_b_value  = w_byp_b ? data_bus : w_b_stored;
  assign gpr.hazard       = (r_busy[gpr.alu_a_select] && !w_byp_a) ||
                            (r_busy[gpr.alu_b_select] && !w_byp_b);
  assign gpr.busy_mask    = r_busy;
  assign gpr.bus_conflict = r_bus_conflict;
endmodule

// File: tb/tb_gp_register_file.sv
module tb_gp_register_file;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        s_reg_write = 0, s_reg_read = 0, s_reserve = 0;
  logic [2:0]  s_isel = 0, s_osel = 0, s_asel = 0, s_bsel = 0, s_rsel = 0;
  logic [15:0] tb_data = 0;

  wire [15:0] bus0, bus1;
  // The bench owns the bus whenever the register file is not reading.
  assign bus0 = s_reg_read ? 'z : tb_data;
  assign bus1 = s_reg_read ? 'z : tb_data;

  gp_register_file_if #(.DATA_W(16), .ADDR_W(3)) ifc0 ();
  gp_register_file_if #(.DATA_W(16), .ADDR_W(3)) ifc1 ();

  assign ifc0.reg_write = s_reg_write;      assign ifc1.reg_write = s_reg_write;
  assign ifc0.input_select = s_isel;        assign ifc1.input_select = s_isel;
  assign ifc0.reg_read = s_reg_read;        assign ifc1.reg_read = s_reg_read;
  assign ifc0.output_select = s_osel;       assign ifc1.output_select = s_osel;
  assign ifc0.alu_a_select = s_asel;        assign ifc1.alu_a_select = s_asel;
  assign ifc0.alu_b_select = s_bsel;        assign ifc1.alu_b_select = s_bsel;
  assign ifc0.reserve = s_reserve;          assign ifc1.reserve = s_reserve;
  assign ifc0.reserve_select = s_rsel;      assign ifc1.reserve_select = s_rsel;

  gp_register_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut0 (
    .clock(clock), .reset(reset), .data_bus(bus0), .gpr(ifc0));
  gp_register_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) dut1 (
    .clock(clock), .reset(reset), .data_bus(bus1), .gpr(ifc1));

  logic [15:0] o_a[2], o_b[2], o_bus[2];
  logic [7:0]  o_busy[2];
  logic        o_haz[2], o_conf[2];
  assign o_a[0] = ifc0.alu_a_value;  assign o_a[1] = ifc1.alu_a_value;
  assign o_b[0] = ifc0.alu_b_value;  assign o_b[1] = ifc1.alu_b_value;
  assign o_bus[0] = bus0;            assign o_bus[1] = bus1;
  assign o_busy[0] = ifc0.busy_mask; assign o_busy[1] = ifc1.busy_mask;
  assign o_haz[0] = ifc0.hazard;     assign o_haz[1] = ifc1.hazard;
  assign o_conf[0] = ifc0.bus_conflict; assign o_conf[1] = ifc1.bus_conflict;

`ifdef GPR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural register contents and busy flags per instance.
  logic [15:0] m_regs[2][8];
  logic [7:0]  m_busy[2];
  logic        m_conf[2];
  bit          model_valid = 0;

  function automatic logic [15:0] m_read(input int d, input logic [2:0] idx);
    return (d == 1 && idx == 0) ? 16'h0000 : m_regs[d][idx];
  endfunction

  function automatic bit m_write_takes(input int d);
    return s_reg_write && !s_reg_read && !(d == 1 && s_isel == 0);
  endfunction

  always @(negedge clock) begin
    if (model_valid) begin
      for (int d = 0; d < 2; d++) begin
        bit fa, fb;
        logic [15:0] ea, eb;
        fa = BYPASS && m_write_takes(d) && s_isel == s_asel;
        fb = BYPASS && m_write_takes(d) && s_isel == s_bsel;
        ea = fa ? tb_data : m_read(d, s_asel);
        eb = fb ? tb_data : m_read(d, s_bsel);
        check($sformatf("alu_a[%0d]", d), {16'h0, o_a[d]}, {16'h0, ea});
        check($sformatf("alu_b[%0d]", d), {16'h0, o_b[d]}, {16'h0, eb});
        check($sformatf("busy[%0d]", d), {24'h0, o_busy[d]}, {24'h0, m_busy[d]});
        check($sformatf("hazard[%0d]", d), {31'h0, o_haz[d]},
              {31'h0, (m_busy[d][s_asel] && !fa) || (m_busy[d][s_bsel] && !fb)});
        check($sformatf("conflict[%0d]", d), {31'h0, o_conf[d]}, {31'h0, m_conf[d]});
        check($sformatf("bus[%0d]", d), {16'h0, o_bus[d]},
              {16'h0, s_reg_read ? m_read(d, s_osel) : tb_data});
      end
    end
    // Advance the model with the inputs that the next rising edge will sample.
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int r = 0; r < 8; r++) m_regs[d][r] = 16'h0;
        m_busy[d] = 8'h00;
        m_conf[d] = 1'b0;
      end else begin
        m_conf[d] = s_reg_write && s_reg_read;
        if (m_write_takes(d)) begin
          m_regs[d][s_isel] = tb_data;
          m_busy[d][s_isel] = 1'b0;
        end
        if (s_reserve && !(d == 1 && s_rsel == 0)) m_busy[d][s_rsel] = 1'b1;
      end
    end
    if (reset) model_valid = 1;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    s_reg_write = 0; s_reg_read = 0; s_reserve = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) cyc();
    reset = 0;
    tb_data = 16'h5A5A;

    // Reset state on every index; bus released when not reading.
    for (int i = 0; i < 8; i++) begin
      s_asel = 3'(i); s_bsel = 3'(i); s_osel = 3'(i); s_reg_read = 0;
      @(negedge clock);
      check("rst_bus_released", {16'h0, bus0}, 32'h5A5A);
      cyc();
      s_reg_read = 1;
      @(negedge clock);
      check("rst_alu_a", {16'h0, o_a[0]}, 32'h0);
      check("rst_bus_read", {16'h0, bus0}, 32'h0);
      check("rst_busy", {24'h0, o_busy[0]}, 32'h0);
      cyc();
    end
    idle();

    // Write BEEF to r3, read back next cycle.
    s_reg_write = 1; s_isel = 3; tb_data = 16'hBEEF;
    cyc();
    idle(); s_asel = 3; s_reg_read = 1; s_osel = 3;
    @(negedge clock);
    check("beef_alu_a", {16'h0, o_a[0]}, 32'hBEEF);
    check("beef_bus", {16'h0, bus0}, 32'hBEEF);
    cyc();

    // Reserve r5, then write it back.
    idle(); s_reserve = 1; s_rsel = 5;
    cyc();
    idle(); s_bsel = 5;
    @(negedge clock);
    check("res5_busy", {24'h0, o_busy[0]}, 32'h20);
    check("res5_hazard", {31'h0, o_haz[0]}, 32'h1);
    cyc();
    s_reg_write = 1; s_isel = 5; tb_data = 16'h1234;
    cyc();
    idle();
    @(negedge clock);
    check("wb5_busy", {24'h0, o_busy[0]}, 32'h0);
    check("wb5_hazard", {31'h0, o_haz[0]}, 32'h0);
    check("wb5_alu_b", {16'h0, o_b[0]}, 32'h1234);
    cyc();

    // Reserve and write the same index on one edge: value lands, busy stays set.
    s_reserve = 1; s_rsel = 2; s_reg_write = 1; s_isel = 2; tb_data = 16'h00AA;
    cyc();
    idle(); s_asel = 2;
    @(negedge clock);
    check("same_edge_val", {16'h0, o_a[0]}, 32'h00AA);
    check("same_edge_busy", {24'h0, o_busy[0]}, 32'h04);
    cyc();

    // Simultaneous write+read: no write, one-cycle conflict pulse.
    s_reg_write = 1; s_reg_read = 1; s_isel = 6; s_osel = 2;
    @(negedge clock);
    check("conflict_read_ok", {16'h0, bus0}, 32'h00AA);
    cyc();
    idle(); s_asel = 6;
    @(negedge clock);
    check("conflict_pulse", {31'h0, o_conf[0]}, 32'h1);
    check("conflict_nowrite", {16'h0, o_a[0]}, 32'h0);
    cyc();
    @(negedge clock);
    check("conflict_clear", {31'h0, o_conf[0]}, 32'h0);
    cyc();

    // Register 0: hard zero on dut1, ordinary on dut0.
    s_reg_write = 1; s_isel = 0; tb_data = 16'hFFFF;
    cyc();
    idle(); s_reserve = 1; s_rsel = 0;
    cyc();
    idle(); s_asel = 0; s_reg_read = 1; s_osel = 0;
    @(negedge clock);
    check("zr_alu_a", {16'h0, o_a[1]}, 32'h0);
    check("zr_bus", {16'h0, bus1}, 32'h0);
    check("zr_busy0", {31'h0, o_busy[1][0]}, 32'h0);
    check("r0_plain_val", {16'h0, o_a[0]}, 32'hFFFF);
    check("r0_plain_busy", {31'h0, o_busy[0][0]}, 32'h1);
    cyc();

    // Reset overrides pending write and reserve.
    reset = 1; s_reg_read = 0; s_reg_write = 1; s_isel = 1; tb_data = 16'h7777;
    s_reserve = 1; s_rsel = 1;
    cyc();
    reset = 0; idle(); s_asel = 1; s_bsel = 3;
    @(negedge clock);
    check("midrst_busy0", {24'h0, o_busy[0]}, 32'h0);
    check("midrst_busy1", {24'h0, o_busy[1]}, 32'h0);
    check("midrst_r1", {16'h0, o_a[0]}, 32'h0);
    check("midrst_r3", {16'h0, o_b[0]}, 32'h0);
    cyc();

    // Write to a reserved register while the ALU is selecting it.
    s_reserve = 1; s_rsel = 4;
    cyc();
    idle(); s_reg_write = 1; s_isel = 4; tb_data = 16'hCAFE; s_asel = 4; s_bsel = 4;
    @(negedge clock);
    check("byp_alu_a", {16'h0, o_a[0]}, BYPASS ? 32'hCAFE : 32'h0);
    check("byp_hazard", {31'h0, o_haz[0]}, BYPASS ? 32'h0 : 32'h1);
    cyc();
    idle();
    @(negedge clock);
    check("byp_next_alu_a", {16'h0, o_a[0]}, 32'hCAFE);
    check("byp_next_hazard", {31'h0, o_haz[0]}, 32'h0);
    cyc();

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 59) == 0);
      s_reg_write = ($urandom_range(0, 1) == 1);
      s_reg_read  = ($urandom_range(0, 3) == 0);
      s_reserve   = ($urandom_range(0, 2) == 0);
      s_isel = 3'($urandom); s_osel = 3'($urandom); s_asel = 3'($urandom);
      s_bsel = 3'($urandom); s_rsel = 3'($urandom);
      tb_data = 16'($urandom);
      cyc();
    end
    reset = 0; idle();
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
